// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-ported data memory between the pipeline MEM stage and a
// DMA/debug port. Each access is issued on a req/ack memory bus. The pipeline
// is stalled until its own access completes. The core has priority, but after
// MAX_CORE_RUN consecutive core grants with DMA waiting, the DMA is served.
//
// Optional feature: define DMEM_ARB_TIMEOUT_EN to add an ack watchdog. It
// aborts a BUSY access after TIMEOUT_CYC cycles without ack and pulses
// bus_err.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   core_re/core_we      MEM-stage load/store, held while core_stall=1
//   core_addr/core_wdata MEM-stage address and store data
//   core_rdata           load data, valid in the cycle core_stall falls
//   core_stall           combinational freeze for IF..MEM stages
//   dma_valid/we/addr/wdata  DMA request, payload held until dma_ready
//   dma_ready            1-cycle pulse, DMA request accepted
//   dma_rvalid/dma_rdata registered DMA read response
//   mem_req/we/addr/wdata  memory request, registered at grant, held to ack
//   mem_ack/mem_rdata    memory completion pulse and read data
//   bus_err              1-cycle pulse on watchdog abort (0 without watchdog)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_CORE_RUN = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_re,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dma_valid,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, CORE_BUSY, DMA_BUSY} state_t;

  state_t     state, state_nxt;
  logic [3:0] run_cnt;
  logic       core_req;
  logic       grant_core;
  logic       grant_dma;
  logic       timeout;
  logic       done;

  // Elaboration-time range check of the configuration.
  if (MAX_CORE_RUN < 1 || MAX_CORE_RUN > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
    $error("dmem_arbiter: MAX_CORE_RUN must be 1..15 and TIMEOUT_CYC 1..255");
  end

  assign core_req = core_re | core_we;

  // The core wins in IDLE unless DMA has already waited out a full run of
  // core grants.
  assign grant_core = (state == IDLE) && core_req &&
                      !(dma_valid && (run_cnt == 4'(MAX_CORE_RUN)));
  assign grant_dma  = (state == IDLE) && !grant_core && dma_valid;

  // A BUSY access ends on ack, or on watchdog abort when that is built in.
  assign done = (state != IDLE) && (mem_ack || timeout);

`ifdef DMEM_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // The ack wins if it arrives in the last allowed cycle.
  assign timeout = (state != IDLE) && !mem_ack && (wd_cnt == 8'(TIMEOUT_CYC - 1));

  // The watchdog counts cycles spent in BUSY and restarts every IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= 8'd0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeout;
      if (state == IDLE) wd_cnt <= 8'd0;
      else               wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  // An aborted core load returns zero instead of whatever is on the bus.
  assign core_stall = core_req & ~((state == CORE_BUSY) & (mem_ack | timeout));
  assign core_rdata = timeout ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dma_ready = 1'b0;
    case (state)
      IDLE: begin
        if (grant_core) begin
          state_nxt = CORE_BUSY;
        end else if (grant_dma) begin
          state_nxt = DMA_BUSY;
          dma_ready = 1'b1;
        end
      end
      CORE_BUSY, DMA_BUSY: begin
        if (mem_ack || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The memory request is captured at grant and stays frozen until
  // completion. A DMA read response is returned one cycle after its ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= 1'b0;
      if (grant_core) begin
        mem_req   <= 1'b1;
        mem_we    <= core_we;
        mem_addr  <= core_addr;
        mem_wdata <= core_wdata;
      end else if (grant_dma) begin
        mem_req   <= 1'b1;
        mem_we    <= dma_we;
        mem_addr  <= dma_addr;
        mem_wdata <= dma_wdata;
      end else if (done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if ((state == DMA_BUSY) && !mem_we) begin
          dma_rvalid <= 1'b1;
          dma_rdata  <= timeout ? '0 : mem_rdata;
        end
      end
    end
  end

  // run_cnt counts consecutive core grants made while DMA is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (!dma_valid || grant_dma)
        run_cnt <= 4'd0;
      else if (grant_core && (run_cnt != 4'(MAX_CORE_RUN)))
        run_cnt <= run_cnt + 4'd1;
    end
  end

endmodule
